// File: rtl/auto_range_period_meter.sv
// Auto-ranging period meter: times 2^NPER_LOG periods of a slow asynchronous input
// and reports the total as an OUT_W-bit mantissa plus a right-shift exponent.
module auto_range_period_meter #(
    parameter int CNT_W       = 32,
    parameter int OUT_W       = 16,
    parameter int NPER_LOG    = 2,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             si,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] prd_mant,
    output logic [4:0]       prd_exp,
    output logic             timeout,
    output logic             ovf
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam int EC_W = NPER_LOG + 1;
    localparam logic [EC_W-1:0]  LAST_EDGE = EC_W'((1 << NPER_LOG) - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] RAW_MAX   = '1;

    typedef enum logic [2:0] {IDLE, ARM, MEAS, NORM, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [CNT_W-1:0] r_raw;
    logic [EC_W-1:0]  r_edge_cnt;
    logic [WD_W-1:0]  r_wdog;
    logic             r_sat;
    logic [4:0]       r_exp;
    logic [OUT_W-1:0] r_prd_mant;
    logic [4:0]       r_prd_exp;
    logic             r_timeout;
    logic             r_ovf;

    logic w_edge;
    logic w_final_edge;
    logic w_wd_expire;
    logic w_fits;

    assign w_edge       = r_sync2 & ~r_sync3;
    assign w_final_edge = (r_state == MEAS) && w_edge && (r_edge_cnt == LAST_EDGE);
    // A final edge landing on the last watchdog cycle still produces a normal result.
    assign w_wd_expire  = ((r_state == ARM) || (r_state == MEAS)) &&
                          (r_wdog == WD_LAST) && !w_final_edge;
    assign w_fits       = (r_raw >> OUT_W) == '0;

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign prd_mant = r_prd_mant;
    assign prd_exp  = r_prd_exp;
    assign timeout  = r_timeout;
    assign ovf      = r_ovf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = ARM;
            ARM: begin
                if (w_wd_expire) w_state_next = DONE;
                else if (w_edge) w_state_next = MEAS;
            end
            MEAS: begin
                if (w_final_edge)     w_state_next = NORM;
                else if (w_wd_expire) w_state_next = DONE;
            end
            NORM: if (w_fits) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_raw      <= '0;
            r_edge_cnt <= '0;
            r_wdog     <= '0;
            r_sat      <= 1'b0;
            r_exp      <= '0;
            r_prd_mant <= '0;
            r_prd_exp  <= '0;
            r_timeout  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_sync1 <= si;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_wdog <= '0;
                        r_sat  <= 1'b0;
                        r_exp  <= '0;
                    end
                end
                ARM: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (w_edge) begin
                        r_raw      <= CNT_W'(1);
                        r_edge_cnt <= '0;
                    end
                end
                MEAS: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (w_edge) r_edge_cnt <= r_edge_cnt + 1'b1;
                    // The count is frozen on the final edge so r_raw holds the total.
                    if (!w_final_edge) begin
                        if (r_raw == RAW_MAX) r_sat <= 1'b1;
                        else                  r_raw <= r_raw + 1'b1;
                    end
                end
                NORM: begin
                    if (!w_fits) begin
                        r_raw <= r_raw >> 1;
                        r_exp <= r_exp + 5'd1;
                    end
                end
                default: ;
            endcase

            // Results are loaded on entry to DONE so they are valid alongside done.
            if (w_wd_expire) begin
                r_prd_mant <= '0;
                r_prd_exp  <= '0;
                r_timeout  <= 1'b1;
                r_ovf      <= r_sat;
            end else if ((r_state == NORM) && w_fits) begin
                r_prd_mant <= r_raw[OUT_W-1:0];
                r_prd_exp  <= r_exp;
                r_timeout  <= 1'b0;
                r_ovf      <= r_sat;
            end
        end
    end

endmodule

// File: tb/tb_auto_range_period_meter.sv
// Randomised bench for auto_range_period_meter: si periods are chosen per transaction
// and the result is predicted from their sum with saturate-then-normalise arithmetic.
module tb_auto_range_period_meter;

    localparam int CNT_W    = 12;
    localparam int OUT_W    = 6;
    localparam int NPER_LOG = 2;
    localparam int TMO      = 10000;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             si    = 1'b0;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] prd_mant;
    logic [4:0]       prd_exp;
    logic             timeout;
    logic             ovf;

    always #5 clk = ~clk;

    auto_range_period_meter #(
        .CNT_W(CNT_W), .OUT_W(OUT_W), .NPER_LOG(NPER_LOG), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .si(si),
        .busy(busy), .done(done), .prd_mant(prd_mant), .prd_exp(prd_exp),
        .timeout(timeout), .ovf(ovf)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [OUT_W-1:0] cap_mant;
    logic [4:0]       cap_exp;
    logic             cap_to;
    logic             cap_ovf;
    int unsigned      pers [4];

    task automatic check_eq(input string tag, input longint obs, input longint expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            cap_mant = prd_mant;
            cap_exp  = prd_exp;
            cap_to   = timeout;
            cap_ovf  = ovf;
        end
    end

    // Reference: clamp the total to the counter range, then halve until it fits.
    function automatic void model(input longint total, output longint mant,
                                  output longint ex, output longint ov);
        longint t;
        t  = total;
        ov = 0;
        ex = 0;
        if (t > (longint'(1) << CNT_W) - 1) begin
            t  = (longint'(1) << CNT_W) - 1;
            ov = 1;
        end
        while (t >= (longint'(1) << OUT_W)) begin
            t  = t / 2;
            ex = ex + 1;
        end
        mant = t;
    endfunction

    task automatic run_meas(input bit extra_start, input string tag);
        int     base;
        bit     seen;
        longint tot, em, ee, eo;
        tot = 0;
        for (int k = 0; k < 4; k++) tot += pers[k];
        model(tot, em, ee, eo);
        base = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_eq({tag, "_busy_rise"}, busy, 1);
        repeat ($urandom_range(2, 10)) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            si = 1'b1;
            if (k == 4) begin
                repeat (3) @(negedge clk);
                si = 1'b0;
            end else begin
                repeat (pers[k] / 2) @(negedge clk);
                si = 1'b0;
                if (extra_start && k == 2) begin
                    start = 1'b1;
                    @(negedge clk) start = 1'b0;
                    repeat (pers[k] - pers[k] / 2 - 1) @(negedge clk);
                end else begin
                    repeat (pers[k] - pers[k] / 2) @(negedge clk);
                end
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done_cnt != base) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, seen, 1);
        repeat (3) @(negedge clk);
        check_eq({tag, "_done_count"}, done_cnt - base, 1);
        check_eq({tag, "_mant"}, cap_mant, em);
        check_eq({tag, "_exp"}, cap_exp, ee);
        check_eq({tag, "_timeout"}, cap_to, 0);
        check_eq({tag, "_ovf"}, cap_ovf, eo);
        check_eq({tag, "_busy_low"}, busy, 0);
        check_eq({tag, "_mant_hold"}, prd_mant, em);
        $display("TXN %s periods %0d %0d %0d %0d total %0d -> mant %0d exp %0d ovf %0d",
                 tag, pers[0], pers[1], pers[2], pers[3], tot, cap_mant, cap_exp, cap_ovf);
    endtask

    task automatic set_pers(input int unsigned a, input int unsigned b,
                            input int unsigned c, input int unsigned d);
        pers[0] = a; pers[1] = b; pers[2] = c; pers[3] = d;
    endtask

    task automatic run_timeout();
        int base;
        int cnt;
        si   = 1'b0;
        base = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cnt = 1;
        while (done !== 1'b1 && cnt < TMO + 50) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("tmo_latency_ok", (cnt >= TMO - 2 && cnt <= TMO + 2), 1);
        repeat (3) @(negedge clk);
        check_eq("tmo_done_count", done_cnt - base, 1);
        check_eq("tmo_flag", cap_to, 1);
        check_eq("tmo_mant", cap_mant, 0);
        check_eq("tmo_exp", cap_exp, 0);
        check_eq("tmo_busy_low", busy, 0);
        $display("TXN timeout latency %0d cycles timeout %0d mant %0d", cnt, cap_to, cap_mant);
    endtask

    task automatic run_reset_abort();
        int base;
        base = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            si = 1'b1; repeat (20) @(negedge clk);
            si = 1'b0; repeat (20) @(negedge clk);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mant", prd_mant, 0);
        check_eq("rst_exp", prd_exp, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_ovf", ovf, 0);
        for (int k = 0; k < 3; k++) begin
            si = 1'b1; repeat (20) @(negedge clk);
            si = 1'b0; repeat (20) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        check_eq("rst_no_done", done_cnt - base, 0);
        check_eq("rst_busy_after", busy, 0);
        $display("TXN reset_abort done pulses %0d busy %0d", done_cnt - base, busy);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("init_busy", busy, 0);
        check_eq("init_done", done, 0);
        check_eq("init_mant", prd_mant, 0);
        check_eq("init_exp", prd_exp, 0);
        check_eq("init_timeout", timeout, 0);
        check_eq("init_ovf", ovf, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        set_pers(16, 16, 16, 16);
        run_meas(1'b0, "fit_edge64");
        set_pers(16, 16, 16, 15);
        run_meas(1'b0, "fit_edge63");
        for (int i = 0; i < 10; i++) begin
            set_pers($urandom_range(6, 1000), $urandom_range(6, 1000),
                     $urandom_range(6, 1000), $urandom_range(6, 1000));
            run_meas(i == 3, (i == 3) ? "rand_restart" : "rand");
        end
        set_pers(2048, 2048, 2048, 2048);
        run_meas(1'b0, "saturate");
        run_timeout();
        set_pers(300, 310, 290, 305);
        run_meas(1'b0, "after_tmo");
        run_reset_abort();
        set_pers(500, 500, 500, 500);
        run_meas(1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
